// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types, width helper and timing defaults for the elevator scheduler
package elevator_pkg;

    localparam int TRAVEL_CYCLES_DEFAULT = 16;
    localparam int DOOR_CYCLES_DEFAULT   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_ARRIVE,
        ST_DOOR
    } state_e;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int level_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// rtl/elevator_req_scan.sv - combinational request scan relative to the car position
//
// Ports:
//   in_levels_i    cabin requests, one bit per level
//   up_levels_i    hall-up requests, levels 0..N-2
//   down_levels_i  hall-down requests, levels 1..N-1
//   level_i        current car level
//   req_here_o     any request at the current level
//   req_above_o    any request at a higher level
//   req_below_o    any request at a lower level
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter  int BUTTONS_WIDTH = 8,
    localparam int LEVEL_W       = level_width(BUTTONS_WIDTH)
) (
    input  logic [BUTTONS_WIDTH-1:0] in_levels_i,
    input  logic [BUTTONS_WIDTH-2:0] up_levels_i,
    input  logic [BUTTONS_WIDTH-1:1] down_levels_i,
    input  logic [LEVEL_W-1:0]       level_i,
    output logic                     req_here_o,
    output logic                     req_above_o,
    output logic                     req_below_o
);

    // Merged per-level request map; the missing hall bits at the ends read as 0.
    logic [BUTTONS_WIDTH-1:0] req_any;

    always_comb begin
        req_any = in_levels_i;
        for (int i = 0; i < BUTTONS_WIDTH - 1; i++) begin
            req_any[i] = req_any[i] | up_levels_i[i];
        end
        for (int i = 1; i < BUTTONS_WIDTH; i++) begin
            req_any[i] = req_any[i] | down_levels_i[i];
        end
    end

    always_comb begin
        req_here_o  = 1'b0;
        req_above_o = 1'b0;
        req_below_o = 1'b0;
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (LEVEL_W'(i) == level_i) req_here_o  = req_any[i];
            if (LEVEL_W'(i) >  level_i) req_above_o = req_above_o | req_any[i];
            if (LEVEL_W'(i) <  level_i) req_below_o = req_below_o | req_any[i];
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - directional SCAN elevator car scheduler with request clear pulses
//
// Ports:
//   clock, reset                 system clock, asynchronous active-low reset
//   active_*_levels              latched cabin / hall-up / hall-down requests
//   inactivate_*_levels          one-cycle clear pulses back to the request latches
//   motor_up, motor_down         motor drive, mutually exclusive
//   door_open                    door drive, never together with a motor output
//   current_level                car position
//   direction_up                 current or last travel direction, 1 = up
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter  int BUTTONS_WIDTH = 8,
    parameter  int TRAVEL_CYCLES = TRAVEL_CYCLES_DEFAULT,
    parameter  int DOOR_CYCLES   = DOOR_CYCLES_DEFAULT,
    localparam int LEVEL_W       = level_width(BUTTONS_WIDTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
    input  logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:1] active_out_down_levels,
    output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
    output logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
    output logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
    output logic                     motor_up,
    output logic                     motor_down,
    output logic                     door_open,
    output logic [LEVEL_W-1:0]       current_level,
    output logic                     direction_up
);

    // One counter serves both MOVE and DOOR since they never overlap.
    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = level_width(CNT_MAX);

    state_e                   state_q;
    logic [LEVEL_W-1:0]       level_q;
    logic                     dir_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     motor_up_q;
    logic                     motor_down_q;
    logic                     door_q;
    logic [BUTTONS_WIDTH-1:0] clr_in_q;
    logic [BUTTONS_WIDTH-2:0] clr_up_q;
    logic [BUTTONS_WIDTH-1:1] clr_dn_q;

    logic                     req_here;
    logic                     req_above;
    logic                     req_below;

    // Pulse pattern for a stop at the current level, and the raw request bits there.
    logic [BUTTONS_WIDTH-1:0] clr_in_d;
    logic [BUTTONS_WIDTH-2:0] clr_up_d;
    logic [BUTTONS_WIDTH-1:1] clr_dn_d;
    logic                     in_here;
    logic                     up_here;
    logic                     dn_here;
    logic                     hall_dir_here;
    logic                     req_ahead;

    elevator_req_scan #(
        .BUTTONS_WIDTH (BUTTONS_WIDTH)
    ) u_scan (
        .in_levels_i   (active_in_levels),
        .up_levels_i   (active_out_up_levels),
        .down_levels_i (active_out_down_levels),
        .level_i       (level_q),
        .req_here_o    (req_here),
        .req_above_o   (req_above),
        .req_below_o   (req_below)
    );

    // A hall call against the travel direction is also cleared when the car is at
    // the end of its sweep, because it will leave in that direction next.
    always_comb begin
        clr_in_d = '0;
        clr_up_d = '0;
        clr_dn_d = '0;
        in_here  = 1'b0;
        up_here  = 1'b0;
        dn_here  = 1'b0;
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (LEVEL_W'(i) == level_q) begin
                in_here     = active_in_levels[i];
                clr_in_d[i] = 1'b1;
            end
        end
        for (int i = 0; i < BUTTONS_WIDTH - 1; i++) begin
            if (LEVEL_W'(i) == level_q) begin
                up_here     = active_out_up_levels[i];
                clr_up_d[i] = dir_q | ~req_below;
            end
        end
        for (int i = 1; i < BUTTONS_WIDTH; i++) begin
            if (LEVEL_W'(i) == level_q) begin
                dn_here     = active_out_down_levels[i];
                clr_dn_d[i] = ~dir_q | ~req_above;
            end
        end
    end

    assign hall_dir_here = dir_q ? up_here   : dn_here;
    assign req_ahead     = dir_q ? req_above : req_below;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            level_q      <= '0;
            dir_q        <= 1'b1;
            cnt_q        <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_q       <= 1'b0;
            clr_in_q     <= '0;
            clr_up_q     <= '0;
            clr_dn_q     <= '0;
        end else begin
            clr_in_q <= '0;
            clr_up_q <= '0;
            clr_dn_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (req_here) begin
                        state_q  <= ST_DOOR;
                        door_q   <= 1'b1;
                        clr_in_q <= clr_in_d;
                        clr_up_q <= clr_up_d;
                        clr_dn_q <= clr_dn_d;
                    end else if (dir_q && req_above) begin
                        state_q    <= ST_MOVE;
                        motor_up_q <= 1'b1;
                    end else if (dir_q && req_below) begin
                        state_q      <= ST_MOVE;
                        dir_q        <= 1'b0;
                        motor_down_q <= 1'b1;
                    end else if (!dir_q && req_below) begin
                        state_q      <= ST_MOVE;
                        motor_down_q <= 1'b1;
                    end else if (!dir_q && req_above) begin
                        state_q    <= ST_MOVE;
                        dir_q      <= 1'b1;
                        motor_up_q <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (cnt_q == CNT_W'(TRAVEL_CYCLES - 1)) begin
                        cnt_q        <= '0;
                        level_q      <= dir_q ? level_q + LEVEL_W'(1) : level_q - LEVEL_W'(1);
                        motor_up_q   <= 1'b0;
                        motor_down_q <= 1'b0;
                        state_q      <= ST_ARRIVE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_ARRIVE: begin
                    if (in_here || hall_dir_here || (!req_ahead && req_here)) begin
                        state_q  <= ST_DOOR;
                        door_q   <= 1'b1;
                        clr_in_q <= clr_in_d;
                        clr_up_q <= clr_up_d;
                        clr_dn_q <= clr_dn_d;
                    end else if (!req_ahead) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q      <= ST_MOVE;
                        motor_up_q   <= dir_q;
                        motor_down_q <= ~dir_q;
                    end
                end
                ST_DOOR: begin
                    if (cnt_q == CNT_W'(DOOR_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        door_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign inactivate_in_levels       = clr_in_q;
    assign inactivate_out_up_levels   = clr_up_q;
    assign inactivate_out_down_levels = clr_dn_q;
    assign motor_up                   = motor_up_q;
    assign motor_down                 = motor_down_q;
    assign door_open                  = door_q;
    assign current_level              = level_q;
    assign direction_up               = dir_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - randomized self-checking bench for elevator_scheduler
module tb_elevator_scheduler;

    localparam int N     = 8;
    localparam int TRAV  = 16;
    localparam int DOORC = 32;
    localparam int LW    = 3;
    localparam int NCYC  = 8000;
    localparam int DIRECTED_END = 120;

    localparam int P_IDLE   = 0;
    localparam int P_TRAVEL = 1;
    localparam int P_PAUSE  = 2;
    localparam int P_DOOR   = 3;

    logic          clock;
    logic          reset;
    logic [N-1:0]  active_in_levels;
    logic [N-2:0]  active_out_up_levels;
    logic [N-1:1]  active_out_down_levels;
    logic [N-1:0]  inactivate_in_levels;
    logic [N-2:0]  inactivate_out_up_levels;
    logic [N-1:1]  inactivate_out_down_levels;
    logic          motor_up;
    logic          motor_down;
    logic          door_open;
    logic [LW-1:0] current_level;
    logic          direction_up;

    // Request latches as buttons_res would hold them, full width; r_up[N-1] and r_dn[0] stay 0.
    logic [N-1:0] r_in;
    logic [N-1:0] r_up;
    logic [N-1:0] r_dn;

    assign active_in_levels       = r_in;
    assign active_out_up_levels   = r_up[N-2:0];
    assign active_out_down_levels = r_dn[N-1:1];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    elevator_scheduler #(
        .BUTTONS_WIDTH (N),
        .TRAVEL_CYCLES (TRAV),
        .DOOR_CYCLES   (DOORC)
    ) dut (
        .clock                      (clock),
        .reset                      (reset),
        .active_in_levels           (active_in_levels),
        .active_out_up_levels       (active_out_up_levels),
        .active_out_down_levels     (active_out_down_levels),
        .inactivate_in_levels       (inactivate_in_levels),
        .inactivate_out_up_levels   (inactivate_out_up_levels),
        .inactivate_out_down_levels (inactivate_out_down_levels),
        .motor_up                   (motor_up),
        .motor_down                 (motor_down),
        .door_open                  (door_open),
        .current_level              (current_level),
        .direction_up               (direction_up)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: car activity, its remaining length, and the pulses expected this cycle.
    int           m_phase;
    int           m_left;
    int           m_level;
    bit           m_up;
    logic [N-1:0] e_pin;
    logic [N-1:0] e_pup;
    logic [N-1:0] e_pdn;

    function automatic bit any_at(input int l);
        return r_in[l] | r_up[l] | r_dn[l];
    endfunction

    function automatic bit any_above(input int l);
        bit r = 1'b0;
        for (int i = l + 1; i < N; i++) r |= any_at(i);
        return r;
    endfunction

    function automatic bit any_below(input int l);
        bit r = 1'b0;
        for (int i = 0; i < l; i++) r |= any_at(i);
        return r;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_left  = 0;
        m_level = 0;
        m_up    = 1'b1;
        e_pin   = '0;
        e_pup   = '0;
        e_pdn   = '0;
    endtask

    task automatic start_door();
        m_phase        = P_DOOR;
        m_left         = DOORC;
        e_pin[m_level] = 1'b1;
        if (m_level < N - 1) e_pup[m_level] = m_up || !any_below(m_level);
        if (m_level > 0)     e_pdn[m_level] = !m_up || !any_above(m_level);
    endtask

    task automatic start_travel();
        m_phase = P_TRAVEL;
        m_left  = TRAV;
    endtask

    // Advance the model by one clock using the requests visible this cycle.
    task automatic model_step();
        bit ahead;
        e_pin = '0;
        e_pup = '0;
        e_pdn = '0;
        case (m_phase)
            P_IDLE: begin
                if (any_at(m_level)) begin
                    start_door();
                end else begin
                    if (m_up && !any_above(m_level) && any_below(m_level))      m_up = 1'b0;
                    else if (!m_up && !any_below(m_level) && any_above(m_level)) m_up = 1'b1;
                    if (m_up ? any_above(m_level) : any_below(m_level)) start_travel();
                end
            end
            P_TRAVEL: begin
                if (m_left == 1) begin
                    m_level += m_up ? 1 : -1;
                    m_phase  = P_PAUSE;
                end else begin
                    m_left--;
                end
            end
            P_PAUSE: begin
                ahead = m_up ? any_above(m_level) : any_below(m_level);
                if (r_in[m_level] || (m_up ? r_up[m_level] : r_dn[m_level]) ||
                    (!ahead && any_at(m_level)))
                    start_door();
                else if (!ahead)
                    m_phase = P_IDLE;
                else
                    start_travel();
            end
            default: begin
                if (m_left == 1) m_phase = P_IDLE;
                else             m_left--;
            end
        endcase
    endtask

    task automatic compare_all();
        check("level",      32'(current_level), 32'(m_level));
        check("dir_up",     32'(direction_up), 32'(m_up));
        check("motor_up",   32'(motor_up),   32'((m_phase == P_TRAVEL) && m_up));
        check("motor_down", 32'(motor_down), 32'((m_phase == P_TRAVEL) && !m_up));
        check("door_open",  32'(door_open),  32'(m_phase == P_DOOR));
        check("clr_in",     32'(inactivate_in_levels),       32'(e_pin));
        check("clr_up",     32'(inactivate_out_up_levels),   32'(e_pup[N-2:0]));
        check("clr_down",   32'(inactivate_out_down_levels), 32'(e_pdn[N-1:1]));
        check("motor_excl", 32'(motor_up & motor_down), 32'd0);
        check("door_motor", 32'(door_open & (motor_up | motor_down)), 32'd0);
    endtask

    initial begin
        logic [N-1:0] prev_pin, prev_pup, prev_pdn;
        bit  prev_door;
        bit  door_seen;
        int  n_resets;
        int  cycle;

        reset     = 1'b0;
        r_in      = '0;
        r_up      = '0;
        r_dn      = '0;
        prev_door = 1'b0;
        door_seen = 1'b0;
        n_resets  = 0;
        model_reset();

        @(negedge clock);
        compare_all();
        reset = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            prev_pin = e_pin;
            prev_pup = e_pup;
            prev_pdn = e_pdn;
            model_step();

            @(posedge clock);
            #1;
            // Requests drop one edge after their clear pulse was shown.
            r_in &= ~prev_pin;
            r_up &= ~prev_pup;
            r_dn &= ~prev_pdn;

            if (c == 0) begin
                r_in = 8'h08;
            end else if (c >= DIRECTED_END) begin
                if ($urandom_range(0, 29) == 0) begin
                    int kind = int'($urandom_range(0, 2));
                    int lvl;
                    if (kind == 0) begin
                        lvl = int'($urandom_range(0, N - 1));
                        r_in[lvl] = 1'b1;
                    end else if (kind == 1) begin
                        lvl = int'($urandom_range(0, N - 2));
                        r_up[lvl] = 1'b1;
                    end else begin
                        lvl = int'($urandom_range(1, N - 1));
                        r_dn[lvl] = 1'b1;
                    end
                end
                // First reset lands while travelling from 2 to 3, later ones at random mid-travel.
                if (n_resets < 5 && m_phase == P_TRAVEL && m_left < TRAV &&
                    ((n_resets == 0) ? (m_level == 2 && m_up) : ($urandom_range(0, 299) == 0))) begin
                    reset = 1'b0;
                    n_resets++;
                    model_reset();
                end
            end

            @(negedge clock);
            cycle = c + 1;
            compare_all();

            // Single cabin call to level 3, first seen in IDLE at cycle 1.
            if (cycle < DIRECTED_END && door_open && !prev_door && !door_seen) begin
                door_seen = 1'b1;
                check("door_entry_latency", 32'(cycle - 1), 32'(1 + 3 * (TRAV + 1)));
            end
            if (cycle == DIRECTED_END) check("door_seen", 32'(door_seen), 32'd1);
            prev_door = door_open;

            if (!reset) reset = 1'b1;
        end

        check("resets_applied", 32'(n_resets > 0), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Elevator car scheduler sitting directly downstream of `buttons_res`. It consumes the latched cabin (`active_in_levels`) and hall (`active_out_up_levels`, `active_out_down_levels`) requests. It runs a directional SCAN policy to drive the motor and door, and returns one-cycle clear pulses on the `inactivate_*` buses so that `buttons_res` drops each request as it is served.

## Interface
- `BUTTONS_WIDTH`, 8, number of levels (≥2).
- `TRAVEL_CYCLES`, 16, clock cycles to move one level.
- `DOOR_CYCLES`, 32, clock cycles the door stays open per stop.
- `clock  in  1`  single system clock, rising edge.
- `reset  in  1`  asynchronous, active-low reset.
- `active_in_levels  in  BUTTONS_WIDTH [N-1:0]`  cabin requests.
- `active_out_up_levels  in  [N-2:0]`  hall-up requests.
- `active_out_down_levels  in  [N-1:1]`  hall-down requests.
- `inactivate_in_levels  out  [N-1:0]`  clear pulses for cabin requests.
- `inactivate_out_up_levels  out  [N-2:0]`  clear pulses for hall-up requests.
- `inactivate_out_down_levels  out  [N-1:1]`  clear pulses for hall-down requests.
- `motor_up  out  1`  car moving up.
- `motor_down  out  1`  car moving down.
- `door_open  out  1`  door open.
- `current_level  out  LEVEL_W`  car position, where `LEVEL_W = max(1, clog2(N))`.
- `direction_up  out  1`  current/last travel direction, 1 = up.

## Operation
- Derived signals, all combinational from inputs and `current_level` (L):
  - `req_here`: `in[L] | up[L] | down[L]`. Non-existent bits (`down[0]`, `up[N-1]`) read as 0.
  - `req_above`: any request of any kind at a level greater than L.
  - `req_below`: any request of any kind at a level less than L.
- States: IDLE, MOVE, ARRIVE, DOOR.
- IDLE:
  - If `req_here`, go to DOOR.
  - Otherwise, if `direction_up`: `req_above` → MOVE up; else `req_below` → set direction down, MOVE.
  - Mirrored when the direction is down.
  - With no requests, stay in IDLE.
- MOVE:
  - `motor_up` or `motor_down` is asserted according to `direction_up`.
  - A counter runs 0..TRAVEL_CYCLES-1. On terminal count, L increments or decrements and the state goes to ARRIVE.
- ARRIVE (one cycle, motor off): stop at L if any of the following holds, otherwise return to MOVE in the same direction:
  - `in[L]`, or
  - the hall call in the travel direction at L, or
  - no requests ahead, i.e. `!req_above` going up or `!req_below` going down. If nothing is ahead and nothing is requested at L, go to IDLE.
- Entering DOOR, the clear pulses fire for exactly one cycle, in the DOOR-entry cycle:
  - `inactivate_in_levels[L]`.
  - `inactivate_out_up_levels[L]` if going up, or if going down with `!req_below`.
  - `inactivate_out_down_levels[L]` if going down, or if going up with `!req_above`.
- DOOR: `door_open` is held for DOOR_CYCLES cycles, then the state goes to IDLE. A request arriving at L during DOOR is served on the next IDLE evaluation, which reopens the door.
- Direction reversal happens only in IDLE.
- L never leaves the range 0..N-1. MOVE is never entered up from N-1 or down from 0, because `req_above`/`req_below` are false there.

## Timing
- Reset values: state IDLE, L=0, `direction_up`=1, counters 0, and all outputs 0, including every `inactivate_*` bit.
- All outputs are registered.
- Reset asserted at any point (mid-MOVE, mid-DOOR) forces the reset values immediately. Position is not retained.
- Request first seen in IDLE at cycle k:
  - Target at level L±d: MOVE occupies cycles k+1 … k+16 for the first level. Each level costs TRAVEL_CYCLES+1 cycles (MOVE plus ARRIVE). DOOR is entered at cycle k+1+d·(TRAVEL_CYCLES+1).
  - Target is the current level: DOOR is entered at k+1.
- The clear pulse and the rise of `door_open` occur in the same cycle.
- `motor_up` and `motor_down` are never high together.
- `door_open` and either motor output are never high together.
- Inputs are treated as synchronous to `clock`. The block adds no synchronizer.

## Structure
- Package `elevator_pkg` holds:
  - the state enum (IDLE, MOVE, ARRIVE, DOOR);
  - the `LEVEL_W` computation function;
  - default constants for TRAVEL_CYCLES and DOOR_CYCLES.
- Sub-module `elevator_req_scan` is purely combinational: it takes the three request buses and L and produces `req_here`, `req_above` and `req_below`. The FSM, the counters and the pulse generation stay in the top module.

## Test plan
Defaults for all scenarios: N=8, TRAVEL_CYCLES=16, DOOR_CYCLES=32.
- **Single cabin call:** after reset, hold `active_in_levels`=8'h08 until cleared. Expect `motor_up` for 3×16 cycles, L stepping 1, 2, 3, then `inactivate_in_levels`=8'h08 for one cycle at k+52, `door_open` high for 32 cycles, then IDLE with all outputs 0.
- **Same-direction hall stop:** at L=0, `up[2]` and `in[5]` are set. Expect a stop at level 2 with a pulse on `inactivate_out_up_levels[2]` only, then continuation to 5 with a pulse on `in[5]`.
- **Opposite hall call skipped:** at L=0, `in[6]` and `down[4]` are set. Expect the car to pass level 4 without stopping, stop at 6, reverse in IDLE, then stop at 4 with a pulse on `inactivate_out_down_levels[4]`.
- **Request at current level:** in IDLE at L=3, set `in[3]`. Expect no motor activity, DOOR entered at k+1, and a one-cycle clear pulse on bit 3.
- **Direction priority:** at L=3 with direction up, requests at levels 0 and 7 arrive together. Expect the car to serve 7 first, then 0.
- **Reset mid-motion:** drive `reset` low mid-MOVE between levels 2 and 3. Expect all outputs 0 and L=0 immediately. After release, expect the car to resume serving the requests still latched.
